// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM LED driver with a shared period counter,
// period-aligned shadow registers and an optional blink gate.
module rgb_pwm_driver #(
    parameter int CNT_W     = 8,
    parameter int BLINK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             b_in,
    input  logic [CNT_W-1:0] duty,
    input  logic             blink_en,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_tick
);

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_OFF = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_sh_duty;
    logic [BLINK_DIV-1:0] r_bcnt;
    logic [BLINK_DIV-1:0] w_bcnt_nxt;
    logic                 r_sh_r;
    logic                 r_sh_g;
    logic                 r_sh_b;
    logic                 r_led_r;
    logic                 r_led_g;
    logic                 r_led_b;
    logic                 r_tick;
    logic                 w_wrap;
    logic                 w_pwm;

    assign w_wrap = (r_cnt == '1);
    assign w_pwm  = (r_cnt < r_sh_duty) && (r_state == ST_ON);

    // Blink gate: steady ON unless enabled, then toggles every 2^BLINK_DIV periods
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        if (!blink_en) begin
            w_state_nxt = ST_ON;
            w_bcnt_nxt  = '0;
        end else if (w_wrap) begin
            w_bcnt_nxt = r_bcnt + 1'b1;
            if (r_bcnt == '1) begin
                w_state_nxt = (r_state == ST_ON) ? ST_OFF : ST_ON;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bcnt    <= '0;
            r_state   <= ST_ON;
            r_sh_duty <= '0;
            r_sh_r    <= 1'b0;
            r_sh_g    <= 1'b0;
            r_sh_b    <= 1'b0;
            r_led_r   <= 1'b0;
            r_led_g   <= 1'b0;
            r_led_b   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_tick  <= w_wrap;
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_led_r <= r_sh_r & w_pwm;
            r_led_g <= r_sh_g & w_pwm;
            r_led_b <= r_sh_b & w_pwm;
            if (w_wrap) begin
                r_sh_duty <= duty;
                r_sh_r    <= r_in;
                r_sh_g    <= g_in;
                r_sh_b    <= b_in;
            end
        end
    end

    assign led_r       = r_led_r;
    assign led_g       = r_led_g;
    assign led_b       = r_led_b;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: scoreboard bench with a period-level reference model,
// directed scenarios followed by randomized inputs.
module tb_rgb_pwm_driver;

    localparam int CNT_W = 4;
    localparam int BD    = 1;
    localparam int PER   = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             r_in = 1'b0;
    logic             g_in = 1'b0;
    logic             b_in = 1'b0;
    logic [CNT_W-1:0] duty = '0;
    logic             blink_en = 1'b0;
    logic             led_r;
    logic             led_g;
    logic             led_b;
    logic             period_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] expq[$];

    // reference model state: position in period, latched settings, wraps while blinking
    int m_cnt  = 0;
    int m_duty = 0;
    int m_nw   = 0;
    bit m_r    = 0;
    bit m_g    = 0;
    bit m_b    = 0;

    rgb_pwm_driver #(
        .CNT_W(CNT_W),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .r_in(r_in),
        .g_in(g_in),
        .b_in(b_in),
        .duty(duty),
        .blink_en(blink_en),
        .led_r(led_r),
        .led_g(led_g),
        .led_b(led_b),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // model: one step per rising edge, expected post-edge outputs queued
    initial begin
        logic [3:0] e;
        bit on;
        bit lvl;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt  = 0;
                m_duty = 0;
                m_nw   = 0;
                m_r    = 0;
                m_g    = 0;
                m_b    = 0;
                e      = 4'b0000;
            end else begin
                on  = ((m_nw >> BD) % 2) == 0;
                lvl = (m_cnt < m_duty) && on;
                e   = {m_r && lvl, m_g && lvl, m_b && lvl, m_cnt == PER - 1};
                if (m_cnt == PER - 1) begin
                    m_duty = int'(duty);
                    m_r    = r_in;
                    m_g    = g_in;
                    m_b    = b_in;
                end
                if (!blink_en) m_nw = 0;
                else if (m_cnt == PER - 1) m_nw = m_nw + 1;
                m_cnt = (m_cnt + 1) % PER;
            end
            expq.push_back(e);
        end
    end

    // monitor: outputs are presented every cycle
    initial begin
        logic [3:0] e;
        logic [3:0] a;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = {led_r, led_g, led_b, period_tick};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    if (n_fail <= 40)
                        $display("FAIL scoreboard t=%0t rgbt got=%b exp=%b",
                                 $time, a, e);
                end
            end
        end
    end

    task automatic check_eq(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // counts led_r high over one 16-cycle window; optionally changes duty at step k
    task automatic window(input int at, input logic [CNT_W-1:0] nd,
                          output int hi);
        hi = 0;
        for (int k = 1; k <= PER; k++) begin
            @(negedge clk);
            hi += int'(led_r);
            if (k == at) duty = nd;
        end
    endtask

    initial begin
        int  hi;
        bit  found;

        repeat (3) @(negedge clk);
        r_in = 1'b1;
        duty = 4'd8;
        rst  = 1'b0;

        window(-1, '0, hi);
        check_eq("post_reset_idle", hi, 0);
        duty = 4'd4;
        window(-1, '0, hi);
        check_eq("duty8", hi, 8);
        window(6, 4'd12, hi);
        check_eq("mid_update_cur", hi, 4);
        duty = 4'd0;
        window(-1, '0, hi);
        check_eq("mid_update_next", hi, 12);
        duty = 4'd15;
        window(-1, '0, hi);
        check_eq("duty0", hi, 0);
        window(-1, '0, hi);
        check_eq("duty15", hi, 15);

        blink_en = 1'b1;
        repeat (5 * PER) @(negedge clk);
        found = 0;
        for (int i = 0; i < 6 * PER && !found; i++) begin
            @(negedge clk);
            if (((m_nw >> BD) % 2) == 1 && m_cnt == 5) found = 1;
        end
        check_eq("blink_off_seen", int'(found), 1);
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("blink_resume", int'(led_r), 1);

        found = 0;
        for (int i = 0; i < 3 * PER && !found; i++) begin
            @(negedge clk);
            if (m_cnt == 9 && led_r) found = 1;
        end
        check_eq("rst_mid_seen", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outs",
                 int'({led_r, led_g, led_b, period_tick}), 0);
        rst = 1'b0;
        window(-1, '0, hi);
        check_eq("rst_mid_idle", hi, 0);
        window(-1, '0, hi);
        check_eq("rst_mid_resume", hi, 15);

        g_in = 1'b1;
        b_in = 1'b1;
        duty = 4'd5;
        repeat (3 * PER) @(negedge clk);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) duty = CNT_W'($urandom);
            if ($urandom_range(0, 19) == 0) r_in = 1'($urandom);
            if ($urandom_range(0, 19) == 0) g_in = 1'($urandom);
            if ($urandom_range(0, 19) == 0) b_in = 1'($urandom);
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
